jtopl_eg_sched: RTL and testbench
=================================

JTOPL_EG_SCHED -- requirements
Module: jtopl_eg_sched

Interface
REQ-001 SHALL have parameter SLOTS, default 18; number of operator slots sequenced per sample round.
REQ-002 SHALL have parameter AM_DIV, default 104; number of full slot rounds per LFO step.
REQ-003 SHALL have port rst_n  input  1  reset; asynchronous, active-low.
REQ-004 SHALL have port clk  input  1  single clock for all state.
REQ-005 SHALL have port cen  input  1  clock enable; slot sequencing and LFO advance only when high.
REQ-006 SHALL have port wr_en  input  1  parameter write strobe; sampled on every clk edge, independent of cen.
REQ-007 SHALL have port wr_slot  input  5  target slot of the write.
REQ-008 SHALL have port wr_sel  input  1  field select: 0 = {ksl[7:6], tl[5:0]}, 1 = amsen (wr_data[0]).
REQ-009 SHALL have port wr_data  input  8  write data.
REQ-010 SHALL have port lfo_hold  input  1  test mode; forces LFO phase and prescaler to zero.
REQ-011 SHALL have port slot  output  5  slot number of the parameters currently presented.
REQ-012 SHALL have port tl  output  6  total level of the presented slot.
REQ-013 SHALL have port ksl  output  2  key-scale level of the presented slot.
REQ-014 SHALL have port amsen  output  1  AM enable of the presented slot.
REQ-015 SHALL have port lfo_mod  output  7  AM LFO phase; bit 6 selects the descending half of the triangle downstream.
REQ-016 SHALL have port zero  output  1  high while the presented slot is 0.

Function
REQ-017 SHALL hold a per-slot parameter store of SLOTS entries × 9 bits (tl, ksl, amsen).
REQ-018 SHALL keep an internal slot counter that advances 0..SLOTS-1 on each clk edge with cen=1 and wraps from SLOTS-1 to 0.
REQ-019 SHALL, on each clk edge with cen=1, register slot/tl/ksl/amsen/zero from the counter's current slot; one-cycle latency; outputs hold while cen=0.
REQ-020 SHALL, on each clk edge with wr_en=1 and wr_slot<SLOTS, update the field selected by wr_sel; other field is unchanged.
REQ-021 SHALL ignore writes with wr_slot>=SLOTS without side effects.
REQ-022 SHALL, when a write and an output capture hit the same slot on the same edge, present the pre-write value; the new value appears on the next visit.
REQ-023 SHALL increment a round prescaler when the counter wraps SLOTS-1 -> 0 with cen=1.
REQ-024 SHALL, when the prescaler equals AM_DIV-1 at a wrap, clear it and increment lfo_mod modulo 128 (127 -> 0) on the same edge.
REQ-025 SHALL, while lfo_hold=1, force prescaler and lfo_mod to 0 on every clk edge regardless of cen; the slot sequence is unaffected.
REQ-026 SHALL present lfo_mod as a registered value, constant across a full slot round.

Reset
REQ-027 SHALL, while rst_n=0, asynchronously clear slot counter, prescaler, lfo_mod, all parameter entries and all outputs (slot=0, tl=0, ksl=0, amsen=0, zero=0).
REQ-028 SHALL, after rst_n deasserts, present slot 0 (zero=1) on the first cen edge.
REQ-029 SHALL, on reset asserted mid-round, discard the partial round; no write issued in that cycle is retained.

Structure
REQ-030 SHALL take SLOTS default, AM_DIV default and the wr_sel field codes from the shared jtopl_pkg package.
REQ-031 SHALL place prescaler and lfo_mod logic in one sub-module, jtopl_am_lfo, with inputs clk, rst_n, cen, round_wrap and lfo_hold, and output lfo_mod.

Verification
REQ-032 SHALL cover: reset, then cen=1 continuously -> slot sequence 0,1,...,17,0; zero=1 exactly on slot 0; all params 0.
REQ-033 SHALL cover: write slot 5 wr_sel=0 data 8'hC7, then wr_sel=1 data 1 -> on slot 5: tl=6'h07, ksl=3, amsen=1; other slots unchanged.
REQ-034 SHALL cover: write slot 9 data 8'h3F on the edge capturing slot 9 -> tl=0 this visit, tl=6'h3F next visit.
REQ-035 SHALL cover: write wr_slot=18 and wr_slot=31 -> no entry changes.
REQ-036 SHALL cover: AM_DIV=2, cen=1 -> lfo_mod steps every 36 cen cycles and wraps 127 -> 0 after 128 steps; assert lfo_hold -> lfo_mod=0 next edge.
REQ-037 SHALL cover: cen toggling 1-of-3 cycles -> outputs change only on cen edges; rst_n low mid-round -> immediate all-zero outputs.

Source files
------------

// File: rtl/jtopl_pkg.sv
// Shared OPL constants, the per-operator parameter record and its write-merge helper.
// Latency: none (declarations only).
// Backpressure: none.
package jtopl_pkg;

  localparam int SLOTS_DEF  = 18;
  localparam int AM_DIV_DEF = 104;

  // wr_sel field codes
  localparam logic WR_SEL_LVL = 1'b0;  // {ksl[7:6], tl[5:0]}
  localparam logic WR_SEL_AM  = 1'b1;  // amsen in bit 0

  typedef struct packed {
    logic       amsen;
    logic [1:0] ksl;
    logic [5:0] tl;
  } op_prm_t;

  // Merge one register write into a stored entry; the unselected field is kept.
  function automatic op_prm_t prm_write(op_prm_t cur, logic sel, logic [7:0] d);
    op_prm_t nxt;
    nxt = cur;
    case (sel)
      WR_SEL_LVL: begin
        nxt.ksl = d[7:6];
        nxt.tl  = d[5:0];
      end
      WR_SEL_AM: nxt.amsen = d[0];
    endcase
    return nxt;
  endfunction

endpackage

// File: rtl/jtopl_am_lfo.sv
// AM LFO: round prescaler dividing slot rounds by AM_DIV, then a 7-bit phase counter.
// Latency: lfo_mod steps on the same edge as the qualifying round wrap.
// Backpressure: none; advances only on cen edges, lfo_hold overrides cen.
module jtopl_am_lfo
  import jtopl_pkg::*;
#(
  parameter int AM_DIV = AM_DIV_DEF
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cen,
  input  logic       round_wrap,
  input  logic       lfo_hold,
  output logic [6:0] lfo_mod
);

  localparam int PW = (AM_DIV > 1) ? $clog2(AM_DIV) : 1;

  logic [PW-1:0] presc;
  logic          presc_top;

  assign presc_top = (presc == PW'(AM_DIV - 1));

  // Count rounds; every AM_DIV-th wrap bumps the phase (mod 128). Hold pins both to zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc   <= '0;
      lfo_mod <= '0;
    end else if (lfo_hold) begin
      presc   <= '0;
      lfo_mod <= '0;
    end else if (cen && round_wrap) begin
      if (presc_top) begin
        presc   <= '0;
        lfo_mod <= lfo_mod + 7'd1;
      end else begin
        presc <= presc + 1'b1;
      end
    end
  end

endmodule

// File: rtl/jtopl_eg_sched.sv
// Operator slot sequencer: per-slot tl/ksl/amsen store, registered presentation, AM LFO.
// Latency: one cen edge from slot counter to outputs; writes visible on the next visit.
// Backpressure: none; cen stalls sequencing, register writes are always accepted.
module jtopl_eg_sched
  import jtopl_pkg::*;
#(
  parameter int SLOTS  = SLOTS_DEF,
  parameter int AM_DIV = AM_DIV_DEF
) (
  input  logic       rst_n,
  input  logic       clk,
  input  logic       cen,
  input  logic       wr_en,
  input  logic [4:0] wr_slot,
  input  logic       wr_sel,
  input  logic [7:0] wr_data,
  input  logic       lfo_hold,
  output logic [4:0] slot,
  output logic [5:0] tl,
  output logic [1:0] ksl,
  output logic       amsen,
  output logic [6:0] lfo_mod,
  output logic       zero
);

  logic [4:0] cnt;
  logic       last_slot;
  logic       wr_ok;
  op_prm_t    prm_mem [SLOTS];
  op_prm_t    cur_prm;

  assign last_slot = (cnt == 5'(SLOTS - 1));
  assign wr_ok     = wr_en && (int'(wr_slot) < SLOTS);
  assign cur_prm   = prm_mem[cnt];

  // Slot counter: 0..SLOTS-1 on cen edges, wrapping back to 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (cen) begin
      cnt <= last_slot ? 5'd0 : cnt + 5'd1;
    end
  end

  // Parameter store: written on any edge, out-of-range slots dropped.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < SLOTS; i++) prm_mem[i] <= '0;
    end else if (wr_ok) begin
      prm_mem[wr_slot] <= prm_write(prm_mem[wr_slot], wr_sel, wr_data);
    end
  end

  // Present the current slot; reading the array before the write lands gives old data on a same-edge hit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot  <= '0;
      tl    <= '0;
      ksl   <= '0;
      amsen <= 1'b0;
      zero  <= 1'b0;
    end else if (cen) begin
      slot  <= cnt;
      tl    <= cur_prm.tl;
      ksl   <= cur_prm.ksl;
      amsen <= cur_prm.amsen;
      zero  <= (cnt == 5'd0);
    end
  end

  jtopl_am_lfo #(
    .AM_DIV(AM_DIV)
  ) u_am_lfo (
    .clk       (clk),
    .rst_n     (rst_n),
    .cen       (cen),
    .round_wrap(last_slot),
    .lfo_hold  (lfo_hold),
    .lfo_mod   (lfo_mod)
  );

endmodule

// File: tb/tb_jtopl_eg_sched.sv
// Directed bench for jtopl_eg_sched: a default instance for sequencing/writes and an AM_DIV=2 instance for the LFO.
module tb_jtopl_eg_sched;
  import jtopl_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n, cen, wr_en, wr_sel, lfo_hold;
  logic [4:0] wr_slot;
  logic [7:0] wr_data;
  logic [4:0] slot;
  logic [5:0] tl;
  logic [1:0] ksl;
  logic       amsen, zero;
  logic [6:0] lfo_mod;

  logic       cen_f, lfo_hold_f;
  logic [4:0] slot_f;
  logic [5:0] tl_f;
  logic [1:0] ksl_f;
  logic       amsen_f, zero_f;
  logic [6:0] lfo_f;

  jtopl_eg_sched u_dut (
    .rst_n(rst_n), .clk(clk), .cen(cen), .wr_en(wr_en), .wr_slot(wr_slot),
    .wr_sel(wr_sel), .wr_data(wr_data), .lfo_hold(lfo_hold), .slot(slot),
    .tl(tl), .ksl(ksl), .amsen(amsen), .lfo_mod(lfo_mod), .zero(zero)
  );

  jtopl_eg_sched #(.SLOTS(18), .AM_DIV(2)) u_fast (
    .rst_n(rst_n), .clk(clk), .cen(cen_f), .wr_en(1'b0), .wr_slot(5'd0),
    .wr_sel(1'b0), .wr_data(8'd0), .lfo_hold(lfo_hold_f), .slot(slot_f),
    .tl(tl_f), .ksl(ksl_f), .amsen(amsen_f), .lfo_mod(lfo_f), .zero(zero_f)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Step with cen=1 until the presented slot equals s (bounded).
  task automatic find_slot(input logic [4:0] s, output bit ok);
    ok = 1'b0;
    cen = 1'b1;
    for (int n = 0; n < 40; n++) begin
      tick();
      if (slot == s) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  // Expected store contents, {amsen, ksl, tl}, written by hand as the test proceeds.
  logic [8:0] exp_mem [18];

  task automatic sweep(input string tag);
    bit ok;
    find_slot(5'd0, ok);
    chk({tag, "_find0"}, int'(ok), 1);
    for (int s = 0; s < 18; s++) begin
      if (s != 0) tick();
      chk({tag, "_slot"}, int'(slot), s);
      chk({tag, "_zero"}, int'(zero), (s == 0) ? 1 : 0);
      chk({tag, "_prm"}, int'({amsen, ksl, tl}), int'(exp_mem[s]));
    end
  endtask

  typedef struct {
    logic [4:0] w_slot;
    logic       w_sel;
    logic [7:0] w_data;
    logic [4:0] probe;
    logic [5:0] e_tl;
    logic [1:0] e_ksl;
    logic       e_am;
  } vec_t;

  vec_t vecs [8];

  initial begin
    bit ok;
    int k;
    int exp_s;

    vecs[0] = '{5'd5,  1'b0, 8'hC7, 5'd5,  6'h07, 2'd3, 1'b0};
    vecs[1] = '{5'd5,  1'b1, 8'h01, 5'd5,  6'h07, 2'd3, 1'b1};
    vecs[2] = '{5'd17, 1'b0, 8'h7F, 5'd17, 6'h3F, 2'd1, 1'b0};
    vecs[3] = '{5'd0,  1'b1, 8'hFF, 5'd0,  6'h00, 2'd0, 1'b1};
    vecs[4] = '{5'd18, 1'b0, 8'hFF, 5'd0,  6'h00, 2'd0, 1'b1};
    vecs[5] = '{5'd31, 1'b1, 8'h01, 5'd15, 6'h00, 2'd0, 1'b0};
    vecs[6] = '{5'd17, 1'b1, 8'h00, 5'd17, 6'h3F, 2'd1, 1'b0};
    vecs[7] = '{5'd0,  1'b1, 8'h00, 5'd0,  6'h00, 2'd0, 1'b0};

    rst_n = 1'b0; cen = 1'b0; wr_en = 1'b0; wr_sel = 1'b0; wr_slot = '0;
    wr_data = '0; lfo_hold = 1'b0; cen_f = 1'b0; lfo_hold_f = 1'b0;
    for (int i = 0; i < 18; i++) exp_mem[i] = '0;

    // Reset state
    #12;
    chk("rst_slot", int'(slot), 0);
    chk("rst_zero", int'(zero), 0);
    chk("rst_prm", int'({amsen, ksl, tl}), 0);
    chk("rst_lfo", int'(lfo_mod), 0);
    tick();
    rst_n = 1'b1;
    cen = 1'b1;

    // Free-running sequence 0..17,0 with all params zero
    for (int n = 0; n < 19; n++) begin
      tick();
      chk("seq_slot", int'(slot), n % 18);
      chk("seq_zero", int'(zero), (n % 18 == 0) ? 1 : 0);
      chk("seq_prm", int'({amsen, ksl, tl}), 0);
    end

    // Table of writes, each followed by a probe of one slot
    for (int i = 0; i < 8; i++) begin
      cen = 1'b0;
      wr_en = 1'b1; wr_slot = vecs[i].w_slot; wr_sel = vecs[i].w_sel; wr_data = vecs[i].w_data;
      tick();
      wr_en = 1'b0;
      find_slot(vecs[i].probe, ok);
      chk("vec_found", int'(ok), 1);
      chk("vec_tl", int'(tl), int'(vecs[i].e_tl));
      chk("vec_ksl", int'(ksl), int'(vecs[i].e_ksl));
      chk("vec_am", int'(amsen), int'(vecs[i].e_am));
    end
    exp_mem[5]  = {1'b1, 2'd3, 6'h07};
    exp_mem[17] = {1'b0, 2'd1, 6'h3F};
    sweep("tbl");

    // Write landing on the same edge that captures slot 9
    find_slot(5'd8, ok);
    chk("hit_find8", int'(ok), 1);
    wr_en = 1'b1; wr_slot = 5'd9; wr_sel = 1'b0; wr_data = 8'h3F;
    tick();
    wr_en = 1'b0;
    chk("hit_slot", int'(slot), 9);
    chk("hit_old_tl", int'(tl), 0);
    find_slot(5'd9, ok);
    chk("hit_find9", int'(ok), 1);
    chk("hit_new_tl", int'(tl), 6'h3F);
    chk("hit_new_ksl", int'(ksl), 0);
    exp_mem[9] = {1'b0, 2'd0, 6'h3F};

    // cen active one cycle in three: outputs move only on cen edges
    exp_s = int'(slot);
    for (int n = 0; n < 12; n++) begin
      cen = (n % 3 == 0);
      tick();
      if (n % 3 == 0) exp_s = (exp_s + 1) % 18;
      chk("cen3_slot", int'(slot), exp_s);
      chk("cen3_prm", int'({amsen, ksl, tl}), int'(exp_mem[exp_s]));
    end

    // Reset mid-round with a write pending: immediate zeros, write lost, store cleared
    find_slot(5'd4, ok);
    chk("mrst_find4", int'(ok), 1);
    wr_en = 1'b1; wr_slot = 5'd3; wr_sel = 1'b0; wr_data = 8'hFF;
    #2;
    rst_n = 1'b0;
    #1;
    chk("mrst_slot", int'(slot), 0);
    chk("mrst_zero", int'(zero), 0);
    chk("mrst_prm", int'({amsen, ksl, tl}), 0);
    wr_en = 1'b0;
    tick();
    rst_n = 1'b1;
    cen = 1'b1;
    tick();
    chk("post_rst_slot", int'(slot), 0);
    chk("post_rst_zero", int'(zero), 1);
    for (int i = 0; i < 18; i++) exp_mem[i] = '0;
    sweep("post_rst");
    cen = 1'b0;

    // AM LFO with AM_DIV=2: one step per 36 cen cycles, wrap 127 -> 0
    lfo_hold_f = 1'b1;
    tick();
    chk("lfo_hold0", int'(lfo_f), 0);
    lfo_hold_f = 1'b0;
    cen_f = 1'b1;
    for (k = 1; k <= 4788; k++) begin
      tick();
      if ((k % 36 == 0) || (k % 36 == 35)) chk("lfo_step", int'(lfo_f), (k / 36) % 128);
    end
    lfo_hold_f = 1'b1;
    tick();
    chk("lfo_hold", int'(lfo_f), 0);
    chk("lfo_hold_slot", int'(slot_f), 0);
    chk("lfo_hold_zero", int'(zero_f), 1);
    cen_f = 1'b0;
    tick();
    chk("lfo_hold_nocen", int'(lfo_f), 0);
    chk("fast_prm", int'({amsen_f, ksl_f, tl_f}), 0);
    chk("main_lfo", int'(lfo_mod), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
